// File: rtl/pin_lock_pkg.sv
// Shared definitions for the keypad lock: state codes, display symbols and width helper.
package pin_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED       = 3'd0,
    ST_UNLOCK_ENTRY = 3'd1,
    ST_UNLOCKED     = 3'd2,
    ST_RELOCK_ENTRY = 3'd3,
    ST_CHG_NEW      = 3'd4,
    ST_CHG_CONFIRM  = 3'd5,
    ST_LOCKOUT      = 3'd6,
    ST_BACKDOOR     = 3'd7
  } state_e;

  // Seven-segment symbol codes; 0..15 are the hex digits themselves.
  localparam logic [4:0] SYM_C     = 5'h0C;
  localparam logic [4:0] SYM_D     = 5'h0D;
  localparam logic [4:0] SYM_E     = 5'h0E;
  localparam logic [4:0] SYM_L     = 5'h10;
  localparam logic [4:0] SYM_S     = 5'h11;
  localparam logic [4:0] SYM_O     = 5'h12;
  localparam logic [4:0] SYM_P     = 5'h13;
  localparam logic [4:0] SYM_N     = 5'h14;
  localparam logic [4:0] SYM_DASH  = 5'h1E;
  localparam logic [4:0] SYM_BLANK = 5'h1F;

  function automatic int idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pin_entry_buf.sv
// Digit slot register and index counter. full_value shows the entry with the
// current sw already placed, so the last-digit decision needs no extra cycle.
module pin_entry_buf
  import pin_lock_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  localparam int VAL_W     = NUM_DIGITS * DIGIT_W,
  localparam int IDX_W     = idx_w(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] sw,
  output logic [VAL_W-1:0]   full_value,
  output logic               last,
  output logic [VAL_W-1:0]   entry,
  output logic [IDX_W-1:0]   idx
);

  logic [VAL_W-1:0] r_entry;
  logic [IDX_W-1:0] r_idx;
  logic [VAL_W-1:0] w_full;
  logic             w_last;

  assign w_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    w_full = r_entry;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_full[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sw;
    end
  end

  // Completing the last digit always leaves the entry state, so the buffer empties.
  always_ff @(posedge clk) begin
    if (rst || clear || (capture && w_last)) begin
      r_entry <= '0;
      r_idx   <= '0;
    end else if (capture) begin
      r_entry <= w_full;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  assign full_value = w_full;
  assign last       = w_last;
  assign entry      = r_entry;
  assign idx        = r_idx;

endmodule

// File: rtl/pin_lock_ctrl.sv
// Keypad lock FSM with confirmed PIN change, timed lockout and backdoor restore.
module pin_lock_ctrl
  import pin_lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_PIN = '0,
  parameter int BACKDOOR_EN    = 1,
  localparam int VAL_W = NUM_DIGITS * DIGIT_W,
  localparam int IDX_W = idx_w(NUM_DIGITS),
  localparam int FC_W  = $clog2(MAX_TRIES + 1),
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ent,
  input  logic               clr,
  input  logic               change,
  input  logic               backdoor,
  input  logic [DIGIT_W-1:0] sw,
  output logic [2:0]         state_o,
  output logic [VAL_W-1:0]   entry_o,
  output logic [IDX_W-1:0]   digit_idx_o,
  output logic [FC_W-1:0]    fail_cnt_o,
  output logic               unlocked_o,
  output logic               pin_changed_o,
  output logic               chg_err_o
);

  state_e           r_state, w_state_nxt;
  logic [VAL_W-1:0] r_pin, w_pin_nxt, r_cand, w_cand_nxt;
  logic [FC_W-1:0]  r_fail_cnt, w_fail_nxt, w_fail_inc;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic             r_chg_ok, w_chg_ok_nxt, r_chg_err, w_chg_err_nxt;
  logic             w_capture, w_clear, w_last;
  logic             w_clr, w_ent, w_chg, w_bd;
  logic [VAL_W-1:0] w_full, w_entry;

  // Only the highest-priority pulse of a coincident set acts.
  assign w_clr = clr;
  assign w_ent = ent & ~clr;
  assign w_chg = change & ~clr & ~ent;
  assign w_bd  = backdoor & ~clr & ~ent & ~change & (BACKDOOR_EN != 0);

  assign w_fail_inc = r_fail_cnt + FC_W'(1);

  pin_entry_buf #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .capture    (w_capture),
    .clear      (w_clear),
    .sw         (sw),
    .full_value (w_full),
    .last       (w_last),
    .entry      (w_entry),
    .idx        (digit_idx_o)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pin_nxt     = r_pin;
    w_cand_nxt    = r_cand;
    w_fail_nxt    = r_fail_cnt;
    w_tmr_nxt     = r_tmr;
    w_chg_ok_nxt  = 1'b0;
    w_chg_err_nxt = 1'b0;
    w_capture     = 1'b0;
    w_clear       = 1'b0;
    case (r_state)
      ST_LOCKED, ST_UNLOCK_ENTRY: begin
        w_clear = w_clr;
        if (w_ent) begin
          w_capture = 1'b1;
          if (!w_last) begin
            w_state_nxt = ST_UNLOCK_ENTRY;
          end else if (w_full == r_pin) begin
            w_state_nxt = ST_UNLOCKED;
            w_fail_nxt  = '0;
          end else if (w_fail_inc >= FC_W'(MAX_TRIES)) begin
            w_state_nxt = ST_LOCKOUT;
            w_fail_nxt  = FC_W'(MAX_TRIES);
            w_tmr_nxt   = TMR_W'(LOCKOUT_CYCLES);
          end else begin
            w_state_nxt = ST_LOCKED;
            w_fail_nxt  = w_fail_inc;
          end
        end else if (w_bd && (r_state == ST_LOCKED)) begin
          w_state_nxt = ST_BACKDOOR;
          w_pin_nxt   = DEFAULT_PIN;
          w_fail_nxt  = '0;
        end
      end
      ST_UNLOCKED, ST_RELOCK_ENTRY: begin
        w_clear = w_clr;
        if (w_ent) begin
          w_capture = 1'b1;
          if (!w_last)               w_state_nxt = ST_RELOCK_ENTRY;
          else if (w_full == r_pin)  w_state_nxt = ST_LOCKED;
          else                       w_state_nxt = ST_UNLOCKED;
        end else if (w_chg && (r_state == ST_UNLOCKED)) begin
          w_state_nxt = ST_CHG_NEW;
          w_clear     = 1'b1;
        end
      end
      ST_CHG_NEW: begin
        w_clear = w_clr;
        if (w_ent) begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_CHG_CONFIRM;
            w_cand_nxt  = w_full;
          end
        end
      end
      ST_CHG_CONFIRM: begin
        w_clear = w_clr;
        if (w_ent) begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_UNLOCKED;
            if (w_full == r_cand) begin
              w_pin_nxt    = r_cand;
              w_chg_ok_nxt = 1'b1;
            end else begin
              w_chg_err_nxt = 1'b1;
            end
          end
        end
      end
      ST_LOCKOUT: begin
        if (r_tmr <= TMR_W'(1)) begin
          w_state_nxt = ST_LOCKED;
          w_fail_nxt  = '0;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      ST_BACKDOOR: begin
        if (w_ent) w_state_nxt = ST_LOCKED;
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_LOCKED;
      r_pin      <= DEFAULT_PIN;
      r_cand     <= '0;
      r_fail_cnt <= '0;
      r_tmr      <= '0;
      r_chg_ok   <= 1'b0;
      r_chg_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pin      <= w_pin_nxt;
      r_cand     <= w_cand_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_tmr      <= w_tmr_nxt;
      r_chg_ok   <= w_chg_ok_nxt;
      r_chg_err  <= w_chg_err_nxt;
    end
  end

  assign state_o       = r_state;
  assign entry_o       = w_entry;
  assign fail_cnt_o    = r_fail_cnt;
  assign unlocked_o    = (r_state == ST_UNLOCKED);
  assign pin_changed_o = r_chg_ok;
  assign chg_err_o     = r_chg_err;

endmodule

// File: doc/pin_lock_ctrl.md
Name: pin_lock_ctrl

Overview:
Parametrised keypad-lock controller. It collects a PIN of NUM_DIGITS digits of DIGIT_W bits each from the switch bank, one digit per ent pulse, and compares it with a stored PIN. Beyond a plain lock/unlock controller, it adds:
- a confirmed (twice-entered) PIN change,
- a timed lockout after MAX_TRIES consecutive failures,
- an optional backdoor reset.
It sits between the debouncers and the seven-segment display formatter, which renders state_o, entry_o and digit_idx_o.

Parameters:
NUM_DIGITS, 4, digits per PIN (>=1)
DIGIT_W, 4, bits per digit
MAX_TRIES, 3, consecutive wrong unlock attempts before lockout (>=1)
LOCKOUT_CYCLES, 100000000, clk cycles spent in LOCKOUT (>=1)
DEFAULT_PIN, 0, PIN after reset/backdoor, width NUM_DIGITS*DIGIT_W
BACKDOOR_EN, 1, 1 = backdoor input honoured, 0 = ignored

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset; one clock; polarity and synchronicity fixed
ent  in  1  debounced single-cycle pulse: capture digit / acknowledge
clr  in  1  debounced pulse: clear current entry
change  in  1  debounced pulse: start PIN change (UNLOCKED only)
backdoor  in  1  debounced pulse: restore DEFAULT_PIN
sw  in  DIGIT_W  digit value
state_o  out  3  current state code (package enum)
entry_o  out  NUM_DIGITS*DIGIT_W  captured digits; digit 0 in MSBs
digit_idx_o  out  IDX_W=$clog2(NUM_DIGITS+1)  digits captured so far
fail_cnt_o  out  $clog2(MAX_TRIES+1)  consecutive failures
unlocked_o  out  1  high while in UNLOCKED
pin_changed_o  out  1  one-cycle pulse on successful change
chg_err_o  out  1  one-cycle pulse on confirm mismatch

Behaviour:
Reset (sync, rst=1 at clk edge):
- state=LOCKED, pin=DEFAULT_PIN, entry=0, idx=0, fail_cnt=0, lock timer=0, all pulses 0.
- rst mid-entry or mid-lockout discards everything, including a pending PIN change.

States: LOCKED, UNLOCK_ENTRY, UNLOCKED, RELOCK_ENTRY, CHG_NEW, CHG_CONFIRM, LOCKOUT, BACKDOOR.

Input priority when pulses coincide: clr > ent > change > backdoor. Only the highest-priority pulse acts.

Entry sub-behaviour (all *_ENTRY, CHG_* states):
- ent captures sw into digit slot idx and increments idx.
- On the ent that captures the last digit (idx==NUM_DIGITS-1), the decision uses the full value including the sw captured that cycle.
- The state transition occurs on the same edge, so the result is visible one cycle after the pulse.
- idx then resets to 0.
- clr: entry=0, idx=0, state unchanged.

Transitions:
- LOCKED: ent -> UNLOCK_ENTRY with that ent capturing digit 0. backdoor (BACKDOOR_EN=1) -> BACKDOOR.
- UNLOCK_ENTRY, last digit:
  - match -> UNLOCKED, fail_cnt=0.
  - mismatch -> fail_cnt+1; if it reaches MAX_TRIES -> LOCKOUT (timer=LOCKOUT_CYCLES), else -> LOCKED.
- UNLOCKED:
  - ent -> RELOCK_ENTRY, capturing digit 0. Last digit: match -> LOCKED; mismatch -> UNLOCKED, fail_cnt untouched.
  - change -> CHG_NEW, entry cleared, no capture.
- CHG_NEW: last digit -> CHG_CONFIRM, candidate latched, entry cleared.
- CHG_CONFIRM, last digit:
  - equal to candidate -> pin<=candidate, pin_changed_o pulse, -> UNLOCKED.
  - else -> chg_err_o pulse, pin unchanged, -> UNLOCKED.
- LOCKOUT:
  - All inputs except rst ignored, including backdoor.
  - Timer decrements each cycle; at 1 -> LOCKED, fail_cnt=0.
- BACKDOOR:
  - On entry: pin<=DEFAULT_PIN, fail_cnt=0, entry=0.
  - ent -> LOCKED.

Outputs and widths:
- entry_o is cleared on every exit from an entry state.
- Counters saturate; there is no wrap.
- Unused state codes recover to LOCKED on the next edge.

Decomposition:
- Shared package pin_lock_pkg holds:
  - state enum (3-bit codes),
  - display symbol constants (C, L, S, d, O, P, E, n, dash, blank; 5-bit),
  - function idx_w(n).
- One sub-module, pin_entry_buf. It holds the digit shift/slot register and the idx counter, with ports capture, clear, sw, full_value, last.
- The FSM, fail counter and lockout timer stay in pin_lock_ctrl.

Test Plan:
Configuration for all scenarios: NUM_DIGITS=4, DIGIT_W=4, DEFAULT_PIN=16'h0000, MAX_TRIES=3, LOCKOUT_CYCLES=16.
1. Reset, then ent x4 with sw=0 -> UNLOCKED one cycle after 4th ent; unlocked_o=1, fail_cnt_o=0.
2. Unlock, change, enter 1,2,3,4 then 1,2,3,4 -> pin_changed_o one pulse, pin=16'h1234. Relock with 1,2,3,4 -> LOCKED. Unlock with 0,0,0,0 fails, fail_cnt_o=1.
3. Three wrong PINs (9,9,9,9) -> LOCKOUT after 3rd. ent/backdoor during the 16 cycles ignored. Exactly 16 cycles later -> LOCKED, fail_cnt_o=0.
4. Change with 1,2,3,4 then confirm 1,2,3,5 -> chg_err_o pulse, UNLOCKED, old pin still unlocks.
5. Enter 5,6, then clr+ent in the same cycle -> clr wins: entry_o=0, digit_idx_o=0, state UNLOCK_ENTRY.
6. After pin=16'h1234, backdoor in LOCKED -> BACKDOOR. ent -> LOCKED; 0,0,0,0 unlocks. Assert rst during digit 3 -> LOCKED, entry_o=0 next cycle.
